// File: rtl/cga_alu_pkg.sv
// Shared types and constants for the CGA ALU bus sequencers.
package cga_alu_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RELEASE = 2'd3
  } cdw_state_e;

  // Word passes through; a byte write replicates the chosen byte into both halves.
  function automatic logic [DATA_W-1:0] cd_pack(input logic [DATA_W-1:0] alu,
                                                input logic              byte_sel,
                                                input logic              left_sel);
    logic [BYTE_W-1:0] b;
    b = left_sel ? alu[DATA_W-1:BYTE_W] : alu[BYTE_W-1:0];
    return byte_sel ? {b, b} : alu;
  endfunction

endpackage

// File: rtl/cga_alu_cdw_tmr.sv
// Clearable saturating cycle counter with a terminal-count compare.
module cga_alu_cdw_tmr
  import cga_alu_pkg::*;
#(
  parameter logic [CNT_W-1:0] TC_VAL = '0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_c_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear has priority so entry into a new state always starts from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_c_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/cga_alu_cdw.sv
// CD bus write sequencer: latches an ALU result and runs the CDREQN/CDACKN
// four-phase handshake with setup timing and a timeout abort.
module cga_alu_cdw
  import cga_alu_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES = 1,
  parameter int unsigned TOUT_CYCLES  = 15
) (
  input  logic              ALUCLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] ALU_15_0,
  input  logic              LDCDWN,
  input  logic              BYTE,
  input  logic              BLEFT,
  input  logic              CDACKN,
  output logic [DATA_W-1:0] CD_15_0,
  output logic              ECDN,
  output logic              CDREQN,
  output logic              BUSY,
  output logic              TOUT,
  output logic              OVR
);

  cdw_state_e        state_q, state_d;
  logic [DATA_W-1:0] cd_q, cd_d;
  logic              ecdn_q, cdreqn_q, busy_q, tout_q, ovr_q;
  logic              tout_d, ovr_d;
  logic              load_c, setup_tc_c, tout_tc_c, tout_clr_c, tout_en_c, setup_en_c;

  assign load_c     = (state_q == ST_IDLE) && !LDCDWN;
  assign setup_en_c = (state_q == ST_SETUP);
  assign tout_en_c  = (state_q == ST_WAIT) || (state_q == ST_RELEASE);
  assign tout_clr_c = (state_d != state_q) &&
                      ((state_d == ST_WAIT) || (state_d == ST_RELEASE));

  cga_alu_cdw_tmr #(
    .TC_VAL(CNT_W'(SETUP_CYCLES - 1))
  ) u_setup_tmr (
    .clk_i (ALUCLK),
    .rst_i (RESET),
    .clr_i (load_c),
    .en_i  (setup_en_c),
    .tc_c_o(setup_tc_c)
  );

  cga_alu_cdw_tmr #(
    .TC_VAL(CNT_W'(TOUT_CYCLES - 1))
  ) u_tout_tmr (
    .clk_i (ALUCLK),
    .rst_i (RESET),
    .clr_i (tout_clr_c),
    .en_i  (tout_en_c),
    .tc_c_o(tout_tc_c)
  );

  // Next state; an acknowledge in the terminal cycle beats the timeout.
  always_comb begin
    state_d = state_q;
    tout_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_c) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        if (setup_tc_c) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!CDACKN) begin
          state_d = ST_RELEASE;
        end else if (tout_tc_c) begin
          state_d = ST_IDLE;
          tout_d  = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (CDACKN) begin
          state_d = ST_IDLE;
        end else if (tout_tc_c) begin
          state_d = ST_IDLE;
          tout_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cd_d  = load_c ? cd_pack(ALU_15_0, BYTE, BLEFT) : cd_q;
  assign ovr_d = ovr_q | ((state_q != ST_IDLE) && !LDCDWN);

  // Bus controls are decoded from the next state so they change with it.
  always_ff @(posedge ALUCLK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      cd_q     <= '0;
      ecdn_q   <= 1'b1;
      cdreqn_q <= 1'b1;
      busy_q   <= 1'b0;
      tout_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cd_q     <= cd_d;
      ecdn_q   <= (state_d == ST_IDLE);
      cdreqn_q <= (state_d != ST_WAIT);
      busy_q   <= (state_d != ST_IDLE);
      tout_q   <= tout_d;
      ovr_q    <= ovr_d;
    end
  end

  assign CD_15_0 = cd_q;
  assign ECDN    = ecdn_q;
  assign CDREQN  = cdreqn_q;
  assign BUSY    = busy_q;
  assign TOUT    = tout_q;
  assign OVR     = ovr_q;

endmodule

// File: tb/tb_cga_alu_cdw.sv
// Randomized scoreboard bench for the CD bus write sequencer.
module tb_cga_alu_cdw;

  localparam int SETUP = 1;
  localparam int TOUTC = 15;

  logic        clk = 1'b0;
  logic        RESET = 1'b1;
  logic [15:0] ALU_15_0 = '0;
  logic        LDCDWN = 1'b1;
  logic        BYTE = 1'b0;
  logic        BLEFT = 1'b0;
  logic        CDACKN = 1'b1;
  logic [15:0] CD_15_0;
  logic        ECDN, CDREQN, BUSY, TOUT, OVR;

  always #5 clk = ~clk;

  cga_alu_cdw #(
    .SETUP_CYCLES(SETUP),
    .TOUT_CYCLES (TOUTC)
  ) dut (
    .ALUCLK  (clk),
    .RESET   (RESET),
    .ALU_15_0(ALU_15_0),
    .LDCDWN  (LDCDWN),
    .BYTE    (BYTE),
    .BLEFT   (BLEFT),
    .CDACKN  (CDACKN),
    .CD_15_0 (CD_15_0),
    .ECDN    (ECDN),
    .CDREQN  (CDREQN),
    .BUSY    (BUSY),
    .TOUT    (TOUT),
    .OVR     (OVR)
  );

  typedef struct {
    logic [15:0] data;
    bit          tout;
    int          wait_c;
    int          busy_c;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   ovr_model = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  function automatic logic [15:0] ref_data(input logic [15:0] a, input bit bsel, input bit bl);
    logic [7:0] b;
    if (!bsel) return a;
    b = bl ? a[15:8] : a[7:0];
    return {b, b};
  endfunction

  // k: WAIT cycle in which CDACKN is driven low (>TOUTC never);
  // r: RELEASE cycle in which CDACKN returns high (>TOUTC never).
  task automatic write_txn(input logic [15:0] data, input bit bsel, input bit bl,
                           input int k, input int r, input bit ovr);
    exp_t e;
    int   wc, rc;
    wc = (k <= TOUTC) ? k : TOUTC;
    rc = (k > TOUTC) ? 0 : ((r <= TOUTC) ? r : TOUTC);
    e.data   = ref_data(data, bsel, bl);
    e.tout   = (k > TOUTC) || (r > TOUTC);
    e.wait_c = wc;
    e.busy_c = SETUP + wc + rc;
    sb_q.push_back(e);
    ALU_15_0 = data; BYTE = bsel; BLEFT = bl; LDCDWN = 1'b0;
    @(posedge clk); #1;
    LDCDWN = 1'b1;
    check("ecdn_after_load", 32'(ECDN), 0);
    check("cdreqn_in_setup", 32'(CDREQN), 1);
    check("busy_after_load", 32'(BUSY), 1);
    for (int s = 0; s < SETUP; s++) begin
      if (ovr && s == 0) begin
        ALU_15_0 = 16'hFFFF; LDCDWN = 1'b0; ovr_model = 1'b1;
      end
      @(posedge clk); #1;
      LDCDWN = 1'b1;
    end
    check("cdreqn_after_setup", 32'(CDREQN), 0);
    for (int i = 1; i <= wc; i++) begin
      if (i == k) CDACKN = 1'b0;
      @(posedge clk); #1;
    end
    for (int j = 1; j <= rc; j++) begin
      if (j == r) CDACKN = 1'b1;
      @(posedge clk); #1;
    end
    CDACKN = 1'b1;
    check("ecdn_end", 32'(ECDN), 1);
    check("cdreqn_end", 32'(CDREQN), 1);
    check("busy_end", 32'(BUSY), 0);
    check("tout_end", 32'(TOUT), 32'(e.tout));
    check("ovr_end", 32'(OVR), 32'(ovr_model));
  endtask

  // Monitor: measures each busy period and scores it when BUSY falls.
  bit          m_pb = 1'b0, m_pr = 1'b1, m_pt = 1'b0;
  int          m_busy = 0, m_req = 0, m_ecdn = 0;
  logic [15:0] m_cap = '0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (RESET) begin
        m_pb = 1'b0; m_pr = 1'b1; m_pt = 1'b0;
        m_busy = 0; m_req = 0; m_ecdn = 0;
      end else begin
        if (m_pt) check("tout_one_cycle", 32'(TOUT), 0);
        if (BUSY) begin
          m_busy++;
          if (!ECDN) m_ecdn++;
          if (!CDREQN) begin
            m_req++;
            if (m_pr) m_cap = CD_15_0;
          end
        end else if (m_pb) begin
          if (sb_q.size() == 0) begin
            check("sb_unexpected_cycle", 1, 0);
          end else begin
            e = sb_q.pop_front();
            check("sb_data", 32'(m_cap), 32'(e.data));
            check("sb_tout", 32'(TOUT), 32'(e.tout));
            check("sb_wait_cycles", m_req, e.wait_c);
            check("sb_busy_cycles", m_busy, e.busy_c);
            check("sb_ecdn_cycles", m_ecdn, e.busy_c);
          end
          m_busy = 0; m_req = 0; m_ecdn = 0;
        end
        m_pb = BUSY; m_pr = CDREQN; m_pt = TOUT;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    RESET = 1'b0;
    check("rst_cd", 32'(CD_15_0), 0);
    check("rst_ecdn", 32'(ECDN), 1);
    check("rst_cdreqn", 32'(CDREQN), 1);
    check("rst_busy", 32'(BUSY), 0);
    check("rst_tout", 32'(TOUT), 0);
    check("rst_ovr", 32'(OVR), 0);
    @(posedge clk); #1;

    write_txn(16'hA5C3, 1'b0, 1'b0, 3, 2, 1'b0);
    write_txn(16'h12F0, 1'b1, 1'b1, 2, 1, 1'b0);
    write_txn(16'h12F0, 1'b1, 1'b0, 1, 3, 1'b0);
    write_txn(16'h3C3C, 1'b0, 1'b0, 99, 1, 1'b0);
    write_txn(16'hBEEF, 1'b0, 1'b0, 2, 2, 1'b0);
    write_txn(16'h0F0F, 1'b0, 1'b0, TOUTC, 2, 1'b0);
    write_txn(16'h7777, 1'b0, 1'b0, 2, 99, 1'b0);

    for (int n = 0; n < 24; n++) begin
      write_txn(16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(1, 17)), int'($urandom_range(1, 17)), 1'b0);
    end

    write_txn(16'h0001, 1'b0, 1'b0, 2, 2, 1'b1);
    write_txn(16'h4321, 1'b0, 1'b0, 1, 1, 1'b0);

    // Abort from WAIT with RESET.
    ALU_15_0 = 16'h5A5A; LDCDWN = 1'b0;
    @(posedge clk); #1;
    LDCDWN = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_in_wait", 32'(CDREQN), 0);
    RESET = 1'b1;
    @(posedge clk); #1;
    check("midrst_ecdn", 32'(ECDN), 1);
    check("midrst_cdreqn", 32'(CDREQN), 1);
    check("midrst_busy", 32'(BUSY), 0);
    check("midrst_cd", 32'(CD_15_0), 0);
    check("midrst_tout", 32'(TOUT), 0);
    check("midrst_ovr", 32'(OVR), 0);
    RESET = 1'b0;
    ovr_model = 1'b0;
    @(posedge clk); #1;

    write_txn(16'hC0DE, 1'b0, 1'b0, 2, 1, 1'b0);

    repeat (3) @(posedge clk);
    check("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cga_alu_cdw.md
Name: cga_alu_cdw

Overview:
- Data-bus write sequencer for the ND120 CGA ALU; opposite direction to the DBR capture path.
- Latches a 16-bit ALU result and drives it onto the shared CD bus.
- Runs a four-phase request/acknowledge handshake with the bus responder, with bus-enable timing and a timeout.
- Sits between the ALU output and the CD bus tristate drivers in the CGA top level.

Parameters:
- SETUP_CYCLES, 1, cycles data is driven (ECDN low) before CDREQN asserts; legal range 1..7.
- TOUT_CYCLES, 15, cycles allowed in each of WAIT and RELEASE before abort; legal range 2..255.

Ports:
- ALUCLK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  synchronous active-high reset, sampled on ALUCLK.
- ALU_15_0  in  16  write data source.
- LDCDWN  in  1  active-low load strobe; starts a write cycle.
- BYTE  in  1  byte write select, sampled with LDCDWN.
- BLEFT  in  1  selects byte for byte writes (1 = ALU_15_0[15:8], 0 = ALU_15_0[7:0]), sampled with LDCDWN.
- CDACKN  in  1  active-low acknowledge from the bus responder.
- CD_15_0  out  16  data to the CD bus drivers.
- ECDN  out  1  active-low CD bus driver enable.
- CDREQN  out  1  active-low bus write request.
- BUSY  out  1  high whenever the state is not IDLE.
- TOUT  out  1  one-cycle pulse on handshake timeout.
- OVR  out  1  sticky flag: a load arrived while BUSY; cleared only by RESET.

Behaviour:
- Reset values:
  - State IDLE.
  - CD_15_0 = 16'h0000.
  - ECDN = 1, CDREQN = 1.
  - BUSY = 0, TOUT = 0, OVR = 0.
  - Setup and timeout counters = 0.
  - RESET mid-cycle aborts immediately: bus released on the next edge, no TOUT pulse.
- Data register:
  - Loaded only on an accepted load (IDLE and LDCDWN = 0).
  - Word write (BYTE = 0): CD_15_0 = ALU_15_0.
  - Byte write (BYTE = 1): the selected byte is replicated into both halves.
  - The register holds its value after the cycle ends. CD_15_0 is valid only while ECDN = 0.
- States (all outputs registered):
  - IDLE: ECDN = 1, CDREQN = 1. LDCDWN = 0 -> load data, clear the setup counter, go to SETUP.
  - SETUP: ECDN = 0, CDREQN = 1. Stays SETUP_CYCLES cycles, then goes to WAIT. CDACKN is ignored in this state.
  - WAIT: ECDN = 0, CDREQN = 0. CDACKN = 0 -> RELEASE.
  - RELEASE: ECDN = 0, CDREQN = 1. CDACKN = 1 -> IDLE (ECDN = 1 on that transition).
- Latency (no ack delay, SETUP_CYCLES = 1): load sampled at edge N -> ECDN low after N, CDREQN low after N+1.
- Timeout:
  - One counter, cleared on entry to WAIT and on entry to RELEASE.
  - It increments each cycle spent in WAIT or RELEASE.
  - When the count reaches TOUT_CYCLES with no qualifying CDACKN edge, go to IDLE with ECDN = 1, CDREQN = 1 and a one-cycle TOUT pulse.
  - If the qualifying CDACKN level arrives in the same cycle the count is reached, the acknowledge wins: normal transition, no TOUT.
- Overrun: LDCDWN = 0 while BUSY -> the load is ignored, the data register is unchanged, OVR is set.
- Back-to-back writes: a load in the cycle right after returning to IDLE is accepted; there is no dead cycle beyond IDLE itself.
- LDCDWN held low continuously:
  - A new cycle starts each time IDLE is reached.
  - OVR sets during the busy cycles. This is intended; software uses it to detect strobe misuse.

Decomposition:
- Shared package cga_alu_pkg holds:
  - the state encoding typedef (IDLE = 0, SETUP = 1, WAIT = 2, RELEASE = 3);
  - the counter width constant (8 bits).
- One natural sub-module: cga_alu_cdw_tmr, the clearable saturating timeout/setup counter with a terminal-count output. It is instantiated twice.

Test Plan:
1. Word write: ALU_15_0 = 16'hA5C3, LDCDWN low one cycle, CDACKN low 2 cycles after CDREQN falls, then high -> CD_15_0 = 16'hA5C3 with ECDN low. Sequence is SETUP 1 cycle, WAIT, RELEASE, IDLE. BUSY drops the cycle after CDACKN rises. TOUT = 0, OVR = 0.
2. Byte writes: ALU_15_0 = 16'h12F0, BYTE = 1.
   - BLEFT = 1 -> CD_15_0 = 16'h1212.
   - Repeat with BLEFT = 0 -> CD_15_0 = 16'hF0F0.
3. Timeout in WAIT: CDACKN held high -> after 15 cycles in WAIT, TOUT pulses for one cycle, ECDN = 1, CDREQN = 1, state IDLE. A following load works normally.
4. Acknowledge versus timeout: CDACKN falls exactly in the 15th WAIT cycle -> RELEASE is entered and TOUT stays 0. Separately, CDACKN stuck low in RELEASE -> timeout pulse after 15 cycles.
5. Overrun: LDCDWN pulsed in SETUP with ALU_15_0 = 16'hFFFF during a write of 16'h0001 -> CD_15_0 stays 16'h0001 and OVR = 1. OVR stays 1 across later cycles until RESET.
6. Reset mid-operation: assert RESET while in WAIT -> next edge gives ECDN = 1, CDREQN = 1, BUSY = 0, CD_15_0 = 16'h0000, TOUT = 0, OVR = 0.
